// File: rtl/ahb_mux_pkg.sv
// ---------------------------------------------------------------------------
// ahb_mux_pkg
//   Shared definitions for the AHB-Lite dmem slave multiplexer.
//   - HTRANS / HRESP encodings
//   - ds_state_t : state of the built-in default (error) slave
//   - dp_kind_t  : what the current data phase is routed to
//   - ahb_decode : base/mask address match for one slave
// ---------------------------------------------------------------------------
package ahb_mux_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE,
    DS_ERR1,
    DS_ERR2
  } ds_state_t;

  // Data-phase owner: nobody (zero-wait OKAY), the default slave, or a real slave.
  typedef enum logic [1:0] {
    DP_NONE,
    DP_DEFAULT,
    DP_SLAVE
  } dp_kind_t;

  // Callers zero-extend narrower addresses to 64 bits.
  function automatic logic ahb_decode(input logic [63:0] addr,
                                      input logic [63:0] base,
                                      input logic [63:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// ---------------------------------------------------------------------------
// ahb_default_slave
//   Two-cycle AHB ERROR responder used for unmapped addresses and for
//   transfers abandoned by the hang watchdog.
// Ports
//   cpu_clk, pwrup_rst_n : clock, async active-low reset
//   start_i              : begin an ERROR response on the next cycle
//   hready_o, hresp_o    : response driven while busy (1/OKAY when idle)
//   busy_o               : high in ERR1/ERR2, i.e. this block owns the response
// ---------------------------------------------------------------------------
module ahb_default_slave
  import ahb_mux_pkg::*;
(
  input  logic cpu_clk,
  input  logic pwrup_rst_n,
  input  logic start_i,
  output logic hready_o,
  output logic hresp_o,
  output logic busy_o
);

  ds_state_t state_q, state_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge cpu_clk or negedge pwrup_rst_n) begin
    if (!pwrup_rst_n) state_q <= DS_IDLE;
    else              state_q <= state_d;
  end

  // NOTE: every output is defaulted before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    hready_o = 1'b1;
    hresp_o  = HRESP_OKAY;
    busy_o   = 1'b0;
    case (state_q)
      DS_IDLE: begin
        if (start_i) state_d = DS_ERR1;
      end
      DS_ERR1: begin
        hready_o = 1'b0;
        hresp_o  = HRESP_ERROR;
        busy_o   = 1'b1;
        state_d  = DS_ERR2;
      end
      DS_ERR2: begin
        hready_o = 1'b1;
        hresp_o  = HRESP_ERROR;
        busy_o   = 1'b1;
        // A transfer accepted during ERR2 may itself be unmapped.
        state_d  = start_i ? DS_ERR1 : DS_IDLE;
      end
      default: state_d = DS_IDLE;
    endcase
  end

endmodule

// File: rtl/ahb_lite_slave_mux_n.sv
// ---------------------------------------------------------------------------
// ahb_lite_slave_mux_n
//   AHB-Lite dmem interconnect: N-slave address decoder, data-phase response
//   mux, built-in default slave, per-transfer hang watchdog and sticky error
//   status for firmware.
// Ports
//   cpu_clk, pwrup_rst_n        : clock, async active-low reset
//   m_haddr, m_htrans           : master address phase
//   m_hready, m_hresp, m_hrdata : response to master (m_hready is also HREADY_IN)
//   s_hsel                      : one-hot slave select, address phase
//   s_hreadyout, s_hresp,
//   s_hrdata                    : per-slave responses, slave i at [i*DW +: DW]
//   err_clear                   : pulse, clears err_valid/err_cause/stuck_mask
//   err_valid, err_cause,
//   err_addr, stuck_mask        : sticky error status
// ---------------------------------------------------------------------------
module ahb_lite_slave_mux_n
  import ahb_mux_pkg::*;
#(
  parameter int                             N_SLAVES    = 4,
  parameter int                             AW          = 32,
  parameter int                             DW          = 32,
  parameter logic [N_SLAVES-1:0][AW-1:0]    SLV_BASE    = '0,
  parameter logic [N_SLAVES-1:0][AW-1:0]    SLV_MASK    = '0,
  parameter int                             TIMEOUT_CYC = 1024
) (
  input  logic                   cpu_clk,
  input  logic                   pwrup_rst_n,
  input  logic [AW-1:0]          m_haddr,
  input  logic [1:0]             m_htrans,
  output logic                   m_hready,
  output logic                   m_hresp,
  output logic [DW-1:0]          m_hrdata,
  output logic [N_SLAVES-1:0]    s_hsel,
  input  logic [N_SLAVES-1:0]    s_hreadyout,
  input  logic [N_SLAVES-1:0]    s_hresp,
  input  logic [N_SLAVES*DW-1:0] s_hrdata,
  input  logic                   err_clear,
  output logic                   err_valid,
  output logic                   err_cause,
  output logic [AW-1:0]          err_addr,
  output logic [N_SLAVES-1:0]    stuck_mask
);

  localparam int WDW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  // ---------------- address decode ----------------
  logic [N_SLAVES-1:0] hit, hit_pri;
  logic                addr_valid, accept, mapped, dflt_start;

  always_comb begin
    hit = '0;
    for (int i = 0; i < N_SLAVES; i++)
      hit[i] = ahb_decode(64'(m_haddr), 64'(SLV_BASE[i]), 64'(SLV_MASK[i]));
  end

  // Isolate the lowest set bit: lowest index wins on overlapping windows.
  assign hit_pri = hit & (~hit + N_SLAVES'(1));

  // A stuck slave is never selected again; its window falls to the default slave.
  assign s_hsel     = hit_pri & ~stuck_mask;
  assign addr_valid = (m_htrans == HTRANS_NONSEQ) || (m_htrans == HTRANS_SEQ);
  assign accept     = m_hready && addr_valid;
  assign mapped     = |s_hsel;
  assign dflt_start = accept && !mapped;

  // ---------------- data-phase routing ----------------
  dp_kind_t            dp_kind_q, dp_kind_d;
  logic [N_SLAVES-1:0] dp_oh_q, dp_oh_d;
  logic [AW-1:0]       dp_addr_q, dp_addr_d;

  logic          slv_hready, slv_hresp, slave_wait;
  logic [DW-1:0] slv_rdata;

  assign slv_hready = |(dp_oh_q & s_hreadyout);
  assign slv_hresp  = |(dp_oh_q & s_hresp);
  assign slave_wait = (dp_kind_q == DP_SLAVE) && !slv_hready;

  always_comb begin
    slv_rdata = '0;
    for (int i = 0; i < N_SLAVES; i++)
      if (dp_oh_q[i]) slv_rdata = slv_rdata | s_hrdata[i*DW +: DW];
  end

  // ---------------- watchdog ----------------
  logic [WDW-1:0] wd_cnt_q, wd_cnt_d;
  logic           wd_fire;

  assign wd_fire = (TIMEOUT_CYC != 0) && slave_wait && (wd_cnt_q == WD_LAST);

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (accept)
      wd_cnt_d = '0;
    else if (slave_wait && (wd_cnt_q != {WDW{1'b1}}))
      wd_cnt_d = wd_cnt_q + WDW'(1);
  end

  always_comb begin
    dp_kind_d = dp_kind_q;
    dp_oh_d   = dp_oh_q;
    dp_addr_d = dp_addr_q;
    if (accept) begin
      dp_addr_d = m_haddr;
      dp_kind_d = mapped ? DP_SLAVE : DP_DEFAULT;
      dp_oh_d   = s_hsel;
    end else if (m_hready) begin
      dp_kind_d = DP_NONE;
      dp_oh_d   = '0;
    end else if (wd_fire) begin
      // Abandon the hung slave; the default slave finishes this data phase.
      dp_kind_d = DP_DEFAULT;
      dp_oh_d   = '0;
    end
  end

  // ---------------- default slave ----------------
  logic ds_hready, ds_hresp, ds_busy, ds_start;

  assign ds_start = dflt_start || wd_fire;

  ahb_default_slave u_default_slave (
    .cpu_clk     (cpu_clk),
    .pwrup_rst_n (pwrup_rst_n),
    .start_i     (ds_start),
    .hready_o    (ds_hready),
    .hresp_o     (ds_hresp),
    .busy_o      (ds_busy)
  );

  // ---------------- response mux ----------------
  always_comb begin
    m_hready = 1'b1;
    m_hresp  = HRESP_OKAY;
    m_hrdata = '0;
    if (ds_busy) begin
      m_hready = ds_hready;
      m_hresp  = ds_hresp;
    end else if (dp_kind_q == DP_SLAVE) begin
      m_hready = slv_hready;
      m_hresp  = slv_hresp;
      m_hrdata = slv_rdata;
    end
  end

  // ---------------- sticky status ----------------
  logic                err_valid_q, err_valid_d;
  logic                err_cause_q, err_cause_d;
  logic [AW-1:0]       err_addr_q,  err_addr_d;
  logic [N_SLAVES-1:0] stuck_q,     stuck_d;

  always_comb begin
    err_valid_d = err_valid_q;
    err_cause_d = err_cause_q;
    err_addr_d  = err_addr_q;
    if (ds_start) begin
      err_valid_d = 1'b1;
      // Keep the first error; a simultaneous clear lets the new one reload.
      if (!err_valid_q || err_clear) begin
        err_cause_d = wd_fire;
        // An unmapped error starts at address-phase acceptance, before dp_addr loads.
        err_addr_d  = wd_fire ? dp_addr_q : m_haddr;
      end
    end else if (err_clear) begin
      err_valid_d = 1'b0;
      err_cause_d = 1'b0;
    end
    stuck_d = (err_clear ? '0 : stuck_q) | (wd_fire ? dp_oh_q : '0);
  end

  always_ff @(posedge cpu_clk or negedge pwrup_rst_n) begin
    if (!pwrup_rst_n) begin
      dp_kind_q   <= DP_NONE;
      dp_oh_q     <= '0;
      dp_addr_q   <= '0;
      wd_cnt_q    <= '0;
      err_valid_q <= 1'b0;
      err_cause_q <= 1'b0;
      err_addr_q  <= '0;
      stuck_q     <= '0;
    end else begin
      dp_kind_q   <= dp_kind_d;
      dp_oh_q     <= dp_oh_d;
      dp_addr_q   <= dp_addr_d;
      wd_cnt_q    <= wd_cnt_d;
      err_valid_q <= err_valid_d;
      err_cause_q <= err_cause_d;
      err_addr_q  <= err_addr_d;
      stuck_q     <= stuck_d;
    end
  end

  assign err_valid  = err_valid_q;
  assign err_cause  = err_cause_q;
  assign err_addr   = err_addr_q;
  assign stuck_mask = stuck_q;

endmodule

// File: tb/tb_ahb_lite_slave_mux_n.sv
// ---------------------------------------------------------------------------
// tb_ahb_lite_slave_mux_n
//   Directed bench: 3 slaves at FF01_0000 / FFFF_0000 / FF00_0000 (64 KiB
//   windows), watchdog limit 8. Inputs change 1 ns after the rising edge and
//   outputs are compared 1 ns later, well away from the edge.
// ---------------------------------------------------------------------------
module tb_ahb_lite_slave_mux_n;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [N-1:0][AW-1:0] BASE = {32'hFF00_0000, 32'hFFFF_0000, 32'hFF01_0000};
  localparam logic [N-1:0][AW-1:0] MASK = {3{32'hFFFF_0000}};

  logic            cpu_clk = 1'b0;
  logic            pwrup_rst_n;
  logic [AW-1:0]   m_haddr;
  logic [1:0]      m_htrans;
  logic            m_hready, m_hresp;
  logic [DW-1:0]   m_hrdata;
  logic [N-1:0]    s_hsel, s_hreadyout, s_hresp, stuck_mask;
  logic [N*DW-1:0] s_hrdata;
  logic            err_clear, err_valid, err_cause;
  logic [AW-1:0]   err_addr;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 cpu_clk = ~cpu_clk;

  ahb_lite_slave_mux_n #(
    .N_SLAVES(N), .AW(AW), .DW(DW),
    .SLV_BASE(BASE), .SLV_MASK(MASK), .TIMEOUT_CYC(8)
  ) dut (
    .cpu_clk     (cpu_clk),
    .pwrup_rst_n (pwrup_rst_n),
    .m_haddr     (m_haddr),
    .m_htrans    (m_htrans),
    .m_hready    (m_hready),
    .m_hresp     (m_hresp),
    .m_hrdata    (m_hrdata),
    .s_hsel      (s_hsel),
    .s_hreadyout (s_hreadyout),
    .s_hresp     (s_hresp),
    .s_hrdata    (s_hrdata),
    .err_clear   (err_clear),
    .err_valid   (err_valid),
    .err_cause   (err_cause),
    .err_addr    (err_addr),
    .stuck_mask  (stuck_mask)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic addr_phase(input logic [AW-1:0] a);
    m_haddr  = a;
    m_htrans = 2'b10;
  endtask

  // Compare the response currently presented to the master.
  task automatic resp(input string tag, input logic rdy, input logic rsp, input logic [DW-1:0] rd);
    #1;
    check({tag, ".hready"}, m_hready, rdy);
    check({tag, ".hresp"},  m_hresp,  rsp);
    check({tag, ".hrdata"}, m_hrdata, rd);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    pwrup_rst_n = 1'b0;
    m_haddr     = '0;
    m_htrans    = 2'b00;
    s_hreadyout = 3'b111;
    s_hresp     = 3'b000;
    s_hrdata    = '0;
    err_clear   = 1'b0;

    // ---- reset state ----
    #1;
    resp("rst", 1'b1, 1'b0, '0);
    check("rst.err_valid", err_valid, 1'b0);
    check("rst.stuck", stuck_mask, 3'b000);
    #11 pwrup_rst_n = 1'b1;
    tick();

    // ---- 1: slave0 read with 3 wait states ----
    addr_phase(32'hFF01_0004);
    #1 check("t1.hsel", s_hsel, 3'b001);
    tick();
    m_htrans    = 2'b00;
    s_hreadyout = 3'b110;
    for (int w = 0; w < 3; w++) begin
      resp("t1.wait", 1'b0, 1'b0, 32'hxxxx_xxxx & '0 | s_hrdata[31:0]);
      tick();
    end
    s_hreadyout = 3'b111;
    s_hrdata[0 +: 32] = 32'hA5A5_A5A5;
    resp("t1.done", 1'b1, 1'b0, 32'hA5A5_A5A5);
    tick();
    resp("t1.idle", 1'b1, 1'b0, '0);

    // ---- 2: unmapped address ----
    addr_phase(32'h1234_0000);
    #1 check("t2.hsel", s_hsel, 3'b000);
    tick();
    m_htrans = 2'b00;
    resp("t2.err1", 1'b0, 1'b1, '0);
    tick();
    resp("t2.err2", 1'b1, 1'b1, '0);
    tick();
    resp("t2.after", 1'b1, 1'b0, '0);
    check("t2.err_valid", err_valid, 1'b1);
    check("t2.err_cause", err_cause, 1'b0);
    check("t2.err_addr", err_addr, 32'h1234_0000);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    #1 check("t2.cleared", err_valid, 1'b0);

    // ---- 3: watchdog on slave1 ----
    addr_phase(32'hFFFF_0000);
    #1 check("t3.hsel", s_hsel, 3'b010);
    tick();
    m_htrans    = 2'b00;
    s_hreadyout = 3'b101;
    for (int w = 0; w < 8; w++) begin
      resp("t3.wait", 1'b0, 1'b0, '0);
      tick();
    end
    resp("t3.err1", 1'b0, 1'b1, '0);
    check("t3.stuck", stuck_mask, 3'b010);
    check("t3.err_cause", err_cause, 1'b1);
    check("t3.err_addr", err_addr, 32'hFFFF_0000);
    check("t3.err_valid", err_valid, 1'b1);
    tick();
    addr_phase(32'hFFFF_0000);   // issued during ERR2
    resp("t3.err2", 1'b1, 1'b1, '0);
    check("t3.hsel_stuck", s_hsel, 3'b000);
    tick();
    m_htrans = 2'b00;
    resp("t3.dflt1", 1'b0, 1'b1, '0);
    tick();
    resp("t3.dflt2", 1'b1, 1'b1, '0);
    tick();
    resp("t3.idle", 1'b1, 1'b0, '0);
    check("t3.cause_kept", err_cause, 1'b1);
    err_clear   = 1'b1;
    s_hreadyout = 3'b111;
    tick();
    err_clear = 1'b0;
    #1 check("t3.stuck_clr", stuck_mask, 3'b000);

    // ---- 4: back-to-back slave0, unmapped, slave2 ----
    addr_phase(32'hFF01_0008);
    tick();
    s_hrdata[0 +: 32] = 32'h1111_1111;
    addr_phase(32'h1234_5678);
    resp("t4.s0", 1'b1, 1'b0, 32'h1111_1111);
    check("t4.hsel_unmapped", s_hsel, 3'b000);
    tick();
    addr_phase(32'hFF00_0010);
    resp("t4.err1", 1'b0, 1'b1, '0);
    check("t4.hsel_s2", s_hsel, 3'b100);
    tick();
    resp("t4.err2", 1'b1, 1'b1, '0);
    tick();
    m_htrans = 2'b00;
    s_hrdata[64 +: 32] = 32'h2222_2222;
    resp("t4.s2", 1'b1, 1'b0, 32'h2222_2222);
    check("t4.err_addr", err_addr, 32'h1234_5678);
    tick();

    // ---- 5: err_clear together with a new unmapped error ----
    addr_phase(32'h0BAD_0000);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    m_htrans  = 2'b00;
    #1;
    check("t5.err_valid", err_valid, 1'b1);
    check("t5.err_addr", err_addr, 32'h0BAD_0000);
    check("t5.err_cause", err_cause, 1'b0);
    tick();

    // ---- 6: reset during ERR1 (new transfer accepted in ERR2) ----
    addr_phase(32'h0000_0100);
    tick();
    m_htrans = 2'b00;
    resp("t6.err1", 1'b0, 1'b1, '0);
    pwrup_rst_n = 1'b0;
    resp("t6.rst_async", 1'b1, 1'b0, '0);
    tick();
    resp("t6.rst_next", 1'b1, 1'b0, '0);
    check("t6.err_valid", err_valid, 1'b0);
    check("t6.stuck", stuck_mask, 3'b000);
    pwrup_rst_n = 1'b1;
    tick();
    resp("t6.post", 1'b1, 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
